// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory port arbiter with watchdog timeout
//
// Purpose: shares one memory/peripheral port between instruction fetch
// (read-only) and load/store data access, one transaction at a time. A
// watchdog completes any transaction stalled longer than TIMEOUT_CYCLES
// with an error flag (TIMEOUT_CYCLES = 0 disables it).
//
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN for alternating
// priority on ties; otherwise data always beats fetch.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   if_req/if_addr          fetch request, held until if_gnt
//   if_gnt                  combinational accept for fetch
//   if_valid/if_rdata/if_err  registered fetch completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request, held until d_gnt
//   d_gnt                   combinational accept for data
//   d_valid/d_rdata/d_err   registered data completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request side
//   mem_ack/mem_rdata       memory completion, read data same cycle
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_gnt,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int SW = DATA_WIDTH / 8;
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_D  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic [CW-1:0]         r_cnt;

  logic                  r_if_valid;
  logic                  r_if_err;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic                  r_d_valid;
  logic                  r_d_err;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic w_pick_d;
  logic w_pick_if;
  logic w_timeout;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = data was granted last; reset value (fetch) lets data win the first tie.
  logic r_last_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_d <= 1'b0;
    end else if (d_gnt) begin
      r_last_d <= 1'b1;
    end else if (if_gnt) begin
      r_last_d <= 1'b0;
    end
  end

  assign w_pick_d = d_req && (!if_req || !r_last_d);
`else
  assign w_pick_d = d_req;
`endif
  assign w_pick_if = if_req && !w_pick_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_d) begin
          d_gnt  = 1'b1;
          w_next = S_BUSY_D;
        end else if (w_pick_if) begin
          if_gnt = 1'b1;
          w_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        // A late ack on the threshold cycle still counts as a normal completion.
        if (mem_ack) begin
          w_next = S_IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_cnt      <= '0;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_gnt) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            // Reads never present byte enables on the bus.
            r_wstrb <= d_we ? d_wstrb : '0;
            r_cnt   <= '0;
          end else if (if_gnt) begin
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_cnt   <= '0;
          end
        end
        S_BUSY_IF: begin
          if (mem_ack) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_rdata;
          end else if (w_timeout) begin
            r_if_valid <= 1'b1;
            r_if_err   <= 1'b1;
            r_if_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_BUSY_D: begin
          if (mem_ack) begin
            r_d_valid <= 1'b1;
            if (!r_we) begin
              r_d_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_d_valid <= 1'b1;
            r_d_err   <= 1'b1;
            r_d_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // mem_req decodes straight from state so an async reset drops it at once.
  assign mem_req   = (r_state != S_IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  assign if_valid  = r_if_valid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_valid   = r_d_valid;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_at;     // busy cycle carrying mem_ack; 0 = never
    logic [31:0] rdata;
    int          exp_busy;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mstrb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int busy;
    @(negedge clock);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    check({tag, "_gnt"}, {31'd0, v.is_d ? d_gnt : if_gnt}, 32'd1);
    check({tag, "_other_gnt"}, {31'd0, v.is_d ? if_gnt : d_gnt}, 32'd0);
    @(negedge clock);
    // Fields change after the grant; the bus must keep the sampled values.
    if_req = 1'b0; d_req = 1'b0;
    if_addr = 32'hDEAD_BEEF; d_addr = 32'hDEAD_BEEF; d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'hA; d_we = ~v.we;
    busy = 0;
    for (int k = 1; k <= 40; k++) begin
      mem_ack   = (k == v.ack_at);
      mem_rdata = (k == v.ack_at) ? v.rdata : 32'h5A5A_0000 + k;
      #1;
      if (!mem_req) break;
      busy++;
      check({tag, "_mem_addr"}, mem_addr, v.addr);
      check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.is_d && v.we});
      check({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_mstrb});
      if (v.is_d && v.we) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
      @(negedge clock);
    end
    mem_ack = 1'b0;
    check({tag, "_busy_cycles"}, busy, v.exp_busy);
    check({tag, "_valid"}, {31'd0, v.is_d ? d_valid : if_valid}, 32'd1);
    check({tag, "_other_valid"}, {31'd0, v.is_d ? if_valid : d_valid}, 32'd0);
    check({tag, "_err"}, {31'd0, v.is_d ? d_err : if_err}, {31'd0, v.exp_err});
    check({tag, "_rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    @(negedge clock);
    #1;
    check({tag, "_valid_drop"}, {31'd0, v.is_d ? d_valid : if_valid}, 32'd0);
    check({tag, "_err_drop"}, {31'd0, v.is_d ? d_err : if_err}, 32'd0);
  endtask

  initial begin
    bit   exp_d;
    bit   seen;
    vec_t rv;

    // is_d we addr wdata wstrb ack_at rdata exp_busy exp_err exp_rdata exp_mstrb
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1,  32'h00A0_0093, 1,  1'b0, 32'h00A0_0093, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 2,  32'h1234_5678, 2,  1'b0, 32'h1234_5678, 4'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h3F, 4'hF, 3, 32'hFFFF_FFFF, 3,  1'b0, 32'h1234_5678, 4'hF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0,  32'h0,         16, 1'b1, 32'h0,         4'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 16, 32'hCAFE_F00D, 16, 1'b0, 32'hCAFE_F00D, 4'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 0,  32'h0,         16, 1'b1, 32'h0,         4'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0104, 32'h55, 4'h3, 1, 32'h7777_7777, 1,  1'b0, 32'hCAFE_F00D, 4'h3};

    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("rst_errs", {30'd0, if_err, d_err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Tie: both requesters held, ack in the first busy cycle each time.
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; d_wstrb = 4'h0;
    mem_rdata = 32'h0;
    #1;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("tie%0d_d_gnt", g), {31'd0, d_gnt}, {31'd0, exp_d});
      check($sformatf("tie%0d_if_gnt", g), {31'd0, if_gnt}, {31'd0, !exp_d});
      @(negedge clock);
      mem_ack = 1'b1;
      if (g == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      #1;
      check($sformatf("tie%0d_mem_addr", g), mem_addr, exp_d ? 32'h0000_0400 : 32'h0000_0020);
      @(negedge clock);
      mem_ack = 1'b0;
      #1;
    end
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // mem_ack while idle must not produce a completion.
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check("idle_ack_valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_ack_d_rdata", d_rdata, 32'hCAFE_F00D);

    // Back-to-back: data granted in the same cycle fetch completes.
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h0000_0030;
    @(negedge clock);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0AAA;
    @(negedge clock);
    mem_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_wstrb = 4'h0;
    #1;
    check("b2b_if_valid", {31'd0, if_valid}, 32'd1);
    check("b2b_if_rdata", if_rdata, 32'h0000_0AAA);
    check("b2b_d_gnt", {31'd0, d_gnt}, 32'd1);
    @(negedge clock);
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0BBB;
    #1;
    check("b2b_mem_req", {31'd0, mem_req}, 32'd1);
    check("b2b_mem_addr", mem_addr, 32'h0000_0500);
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check("b2b_d_valid", {31'd0, d_valid}, 32'd1);
    check("b2b_d_rdata", d_rdata, 32'h0000_0BBB);

    // Reset in the middle of a fetch.
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(negedge clock);
    if_req = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_mem_addr", mem_addr, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      seen = seen | if_valid | mem_req;
    end
    check("rstmid_no_valid", {31'd0, seen}, 32'd0);
    rv = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h1111_2222, 2, 1'b0, 32'h1111_2222, 4'h0};
    run_vec(rv, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
